mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multicycle load/store bus sequencer between the kianV control FSM and the data memory bus. It accepts one load or store request at a time and checks alignment. It builds byte strobes and replicated write data, runs a valid/ready bus transaction with a watchdog, and returns the raw read word plus the latched address low bits. The load alignment/sign-extension stage directly downstream consumes that word and those bits.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles to wait for `mem_ready` before aborting; 0 disables the watchdog.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request strobe from control FSM
- `req_ready`  out  1  unit idle and able to accept
- `req_store`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 treated as word
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, value in low bits
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  raw memory word (loads), held until next accepted load
- `resp_addr_lo`  out  2  `req_addr[1:0]` of the completed access, held
- `resp_misaligned`  out  1  valid with `resp_valid`: alignment fault, no bus access made
- `resp_timeout`  out  1  valid with `resp_valid`: watchdog abort
- `mem_valid`  out  1  bus request
- `mem_ready`  in  1  bus acknowledge
- `mem_addr`  out  32  `{req_addr[31:2], 2'b00}`
- `mem_wdata`  out  32  replicated store data
- `mem_wstrb`  out  4  byte enables; 0000 for loads
- `mem_rdata`  in  32  read data, sampled when `mem_valid & mem_ready`

## Operation
- States: IDLE, BUS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch store/size/addr/wdata.
  - Misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0): go to RESP with `resp_misaligned`=1. `mem_valid` never asserts.
  - Otherwise go to BUS and clear the watchdog counter.
- BUS: `mem_valid`=1. `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable until handshake.
  - On `mem_ready`: for loads, capture `mem_rdata` into `resp_rdata`; go to RESP.
  - Else the counter increments. When it reaches `TIMEOUT_CYCLES` (nonzero) without ready, go to RESP with `resp_timeout`=1. `resp_rdata` is unchanged.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. Error flags are 0 outside RESP.
- Strobes:
  - byte: `4'b0001 << addr[1:0]`
  - half: `addr[1] ? 1100 : 0011`
  - word: 1111
- Write data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata` unchanged
- `resp_addr_lo` is updated on every accepted request, including faulting ones.
- `req_valid` outside IDLE is ignored and not queued. `mem_ready` while `mem_valid`=0 is ignored.

## Timing
- Reset values:
  - state IDLE
  - `req_ready`=1 (combinational from state)
  - `mem_valid`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0
  - `resp_valid`=0, `resp_misaligned`=0, `resp_timeout`=0
  - `resp_rdata`=0, `resp_addr_lo`=0, counter=0
- Request accepted at edge N:
  - `mem_valid` high in cycle N+1.
  - With `mem_ready` in N+1, `resp_valid` is high in cycle N+2. Best-case load/store latency is 2 cycles; each wait cycle adds 1.
- Misaligned request accepted at N: `resp_valid` high in cycle N+1.
- Timeout: `mem_valid` high for exactly `TIMEOUT_CYCLES` cycles, then drops. `resp_valid` is high the cycle after.
- `mem_ready` in the same cycle the counter would expire: handshake wins, no timeout.
- Next request can be accepted the cycle after RESP, giving a back-to-back period of 3 cycles minimum.
- `rst` mid-BUS: next edge returns to IDLE, `mem_valid`=0, no `resp_valid` issued.
- All outputs are registered except `req_ready`.

## Test plan
- SW, addr 0x100, wdata 0xDEADBEEF, `mem_ready` immediate -> `mem_addr`=0x100, `mem_wstrb`=1111, `mem_wdata`=0xDEADBEEF, `resp_valid` 2 cycles after accept, no error flags.
- SB, addr 0x203, wdata 0x000000A5 -> `mem_addr`=0x200, `mem_wstrb`=1000, `mem_wdata`=0xA5A5A5A5. SH, addr 0x202, wdata 0x1234 -> `mem_wstrb`=1100, `mem_wdata`=0x12341234.
- LB, addr 0x1001, `mem_ready` after 3 wait cycles with rdata 0x80FF7F01 -> `mem_wstrb`=0000, `resp_rdata`=0x80FF7F01, `resp_addr_lo`=01, `resp_valid` 5 cycles after accept.
- LW, addr 0x2; SH, addr 0x5 -> `resp_misaligned`=1 and `resp_valid` 1 cycle after accept, `mem_valid` never high, `resp_rdata` unchanged.
- TIMEOUT_CYCLES=4, `mem_ready` held 0 -> `mem_valid` high exactly 4 cycles, then `resp_valid` with `resp_timeout`=1. Variant with ready on the 4th cycle -> normal completion, `resp_timeout`=0.
- `rst` asserted during a BUS wait -> `mem_valid`=0 after that edge, no `resp_valid`, `req_ready`=1. Fresh LW afterwards completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store bus sequencer: accepts one request at a time, checks alignment,
// runs a valid/ready bus transaction under a watchdog and returns the raw word.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_addr_lo,
    output logic        resp_misaligned,
    output logic        resp_timeout,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              store_q, store_d;
    logic              mem_valid_q, mem_valid_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_mis_q, resp_mis_d;
    logic              resp_to_q, resp_to_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        addr_lo_q, addr_lo_d;

    logic              misal;
    logic [3:0]        strb;
    logic [31:0]       wdata_rep;

    // Request decode; size 11 behaves exactly like a word access.
    always_comb begin
        misal     = 1'b0;
        strb      = 4'b1111;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                strb      = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misal     = req_addr[0];
                strb      = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: misal = |req_addr[1:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        resp_valid_d = 1'b0;
        resp_mis_d   = 1'b0;
        resp_to_d    = 1'b0;
        resp_rdata_d = resp_rdata_q;
        addr_lo_d    = addr_lo_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d   = req_store;
                    addr_lo_d = req_addr[1:0];
                    if (misal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = '0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = wdata_rep;
                        mem_wstrb_d = req_store ? strb : 4'b0000;
                    end
                end
            end
            BUS: begin
                // A handshake in the expiry cycle takes priority over the watchdog.
                if (mem_ready) begin
                    if (!store_q) resp_rdata_d = mem_rdata;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    mem_valid_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_to_d    = 1'b1;
                        mem_valid_d  = 1'b0;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_to_q    <= 1'b0;
            resp_rdata_q <= '0;
            addr_lo_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            store_q      <= store_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_mis_q   <= resp_mis_d;
            resp_to_q    <= resp_to_d;
            resp_rdata_q <= resp_rdata_d;
            addr_lo_q    <= addr_lo_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_addr_lo    = addr_lo_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_timeout    = resp_to_q;
    assign mem_valid       = mem_valid_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_wstrb       = mem_wstrb_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table drives requests, a scoreboard queue
// checks each response; reset-during-bus is a hand-written sequence.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned, resp_timeout;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_addr_lo;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_addr_lo(resp_addr_lo),
        .resp_misaligned(resp_misaligned), .resp_timeout(resp_timeout),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] e_maddr, e_mwdata;
        logic [3:0]  e_wstrb;
        logic        e_mis, e_to;
        logic [31:0] e_rdata;
        int          e_lat, e_bus;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  lo;
        logic        mis, to;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_addr_lo", {30'd0, resp_addr_lo}, {30'd0, e.lo});
                chk("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
                chk("resp_timeout", {31'd0, resp_timeout}, {31'd0, e.to});
                chk("resp_cycle", cyc, e.at);
            end
        end
    end

    function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input int w, input logic [31:0] rd,
                                input logic [31:0] ema, input logic [31:0] emw, input logic [3:0] ews,
                                input logic mis, input logic to, input logic [31:0] erd,
                                input int lat, input int nb);
        vec_t v;
        v.store = st; v.size = sz; v.addr = a; v.wdata = wd; v.waits = w; v.rdata = rd;
        v.e_maddr = ema; v.e_mwdata = emw; v.e_wstrb = ews; v.e_mis = mis; v.e_to = to;
        v.e_rdata = erd; v.e_lat = lat; v.e_bus = nb;
        return v;
    endfunction

    // Caller must be at a negedge with the unit idle; returns at a negedge, idle.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   k, n;
        req_store = v.store; req_size = v.size; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        e.rdata = v.e_rdata; e.lo = v.addr[1:0]; e.mis = v.e_mis; e.to = v.e_to;
        e.at = cyc + v.e_lat;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (mem_valid === 1'b1 && k < 20) begin
            chk("mem_addr", mem_addr, v.e_maddr);
            chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.e_wstrb});
            chk("mem_wdata", mem_wdata, v.e_mwdata);
            mem_ready = (k == v.waits);
            mem_rdata = v.rdata;
            k++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        chk("bus_cycles", k, v.e_bus);
        n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("back_to_idle", {31'd0, req_ready}, 32'd1);
    endtask

    vec_t vecs[12];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

        //            st  sz     addr          wdata         w   rdata         e_maddr       e_mwdata      strb     mis to e_rdata       lat bus
        vecs[0]  = mk(1, 2'b10, 32'h0000_0100, 32'hDEADBEEF, 0,  32'h0,        32'h0000_0100, 32'hDEADBEEF, 4'b1111, 0, 0, 32'h0,        2, 1);
        vecs[1]  = mk(1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 0, 32'h0,        32'h0000_0200, 32'hA5A5A5A5, 4'b1000, 0, 0, 32'h0,        2, 1);
        vecs[2]  = mk(1, 2'b01, 32'h0000_0202, 32'h0000_1234, 1, 32'h0,        32'h0000_0200, 32'h12341234, 4'b1100, 0, 0, 32'h0,        3, 2);
        vecs[3]  = mk(0, 2'b00, 32'h0000_1001, 32'h0,        3,  32'h80FF7F01, 32'h0000_1000, 32'h0,        4'b0000, 0, 0, 32'h80FF7F01, 5, 4);
        vecs[4]  = mk(0, 2'b10, 32'h0000_0002, 32'h0,        0,  32'h0,        32'h0,        32'h0,        4'b0000, 1, 0, 32'h80FF7F01, 1, 0);
        vecs[5]  = mk(1, 2'b01, 32'h0000_0005, 32'h0000_FFFF, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 1, 0, 32'h80FF7F01, 1, 0);
        vecs[6]  = mk(0, 2'b10, 32'h0000_0400, 32'h0,        99, 32'h11111111, 32'h0000_0400, 32'h0,        4'b0000, 0, 1, 32'h80FF7F01, 5, 4);
        vecs[7]  = mk(0, 2'b01, 32'h0000_0402, 32'h0,        0,  32'hCAFEF00D, 32'h0000_0400, 32'h0,        4'b0000, 0, 0, 32'hCAFEF00D, 2, 1);
        vecs[8]  = mk(1, 2'b00, 32'h0000_0000, 32'h12345677, 2,  32'h0,        32'h0000_0000, 32'h77777777, 4'b0001, 0, 0, 32'hCAFEF00D, 4, 3);
        vecs[9]  = mk(1, 2'b11, 32'h0000_0010, 32'h01020304, 0,  32'h0,        32'h0000_0010, 32'h01020304, 4'b1111, 0, 0, 32'hCAFEF00D, 2, 1);
        vecs[10] = mk(0, 2'b11, 32'h0000_0011, 32'h0,        0,  32'h0,        32'h0,        32'h0,        4'b0000, 1, 0, 32'hCAFEF00D, 1, 0);
        vecs[11] = mk(0, 2'b10, 32'h0000_0500, 32'h0,        0,  32'h5A5A5A5A, 32'h0000_0500, 32'h0,        4'b0000, 0, 0, 32'h5A5A5A5A, 2, 1);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_flags", {30'd0, resp_misaligned, resp_timeout}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_addr_lo", {30'd0, resp_addr_lo}, 32'd0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset while the bus is stalled: no response, back to idle at once.
        req_store = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0300; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_mem_valid", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_mem_valid_stays_low", {31'd0, mem_valid}, 32'd0);

        run_vec(vecs[11]);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
